// File: rtl/scan_sel_gen_if.sv
// Bundles the control inputs and select/strobe outputs of scan_sel_gen.
// The blank output exists only when SCAN_SEL_BLANK_EN is defined.
interface scan_sel_gen_if;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_val;
    logic       a;
    logic       b;
    logic       c;
    logic       step;
    logic       wrap;
`ifdef SCAN_SEL_BLANK_EN
    logic       blank;
`endif

    modport master (
`ifdef SCAN_SEL_BLANK_EN
        input  blank,
`endif
        output en, mode, load, load_val,
        input  a, b, c, step, wrap
    );

    modport slave (
`ifdef SCAN_SEL_BLANK_EN
        output blank,
`endif
        input  en, mode, load, load_val,
        output a, b, c, step, wrap
    );
endinterface

// File: rtl/scan_sel_gen.sv
// Prescaled 3-bit select sequencer (up/down/ping-pong/hold) driving a 3-to-8 decoder.
// Optional macro SCAN_SEL_BLANK_EN adds a blank output held for BLANK_CYC cycles after each select change.
module scan_sel_gen #(
    parameter int PRESCALE  = 4,
    parameter int CNT_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    scan_sel_gen_if.slave bus
);
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    dir_t             r_dir;
    logic             r_step;
    logic             r_wrap;
    logic             w_tick;

    assign w_tick = bus.en && (r_cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sel  <= 3'd0;
            r_dir  <= DIR_UP;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_sel  <= bus.load_val;
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            // Direction only survives a tick in ping-pong mode
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
            r_step <= 1'b1;
            r_wrap <= 1'b0;
            unique case (bus.mode)
                2'b00: begin
                    r_sel  <= r_sel + 3'd1;
                    r_wrap <= (r_sel == 3'd7);
                end
                2'b01: begin
                    r_sel  <= r_sel - 3'd1;
                    r_wrap <= (r_sel == 3'd0);
                end
                2'b10: begin
                    if (r_dir == DIR_UP) begin
                        if (r_sel != 3'd7) begin
                            r_sel <= r_sel + 3'd1;
                        end else begin
                            r_sel <= 3'd6;
                            r_dir <= DIR_DOWN;
                        end
                    end else begin
                        if (r_sel != 3'd0) begin
                            r_sel <= r_sel - 3'd1;
                            r_dir <= DIR_DOWN;
                        end else begin
                            r_sel  <= 3'd1;
                            r_wrap <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_step <= 1'b0;
                end
            endcase
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.a    = r_sel[2];
    assign bus.b    = r_sel[1];
    assign bus.c    = r_sel[0];
    assign bus.step = r_step;
    assign bus.wrap = r_wrap;

`ifdef SCAN_SEL_BLANK_EN
    logic [7:0] r_blank_cnt;
    logic       r_blank;
    logic       w_change;

    assign w_change = bus.load || (w_tick && (bus.mode != 2'b11));

    // r_blank_cnt holds the remaining extra cycles after the change edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank_cnt <= 8'd0;
            r_blank     <= 1'b0;
        end else if (w_change) begin
            r_blank_cnt <= 8'(BLANK_CYC - 1);
            r_blank     <= 1'b1;
        end else if (r_blank_cnt != 8'd0) begin
            r_blank_cnt <= r_blank_cnt - 8'd1;
        end else begin
            r_blank     <= 1'b0;
        end
    end

    assign bus.blank = r_blank;
`endif
endmodule

// File: tb/tb_scan_sel_gen.sv
// Scoreboard bench for scan_sel_gen: random and directed stimulus against a scan-position model.
// Build with SCAN_SEL_BLANK_EN defined to also check the blank output.
module tb_scan_sel_gen;
    localparam int P  = 4;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_sel_gen_if bus ();

    scan_sel_gen #(.PRESCALE(P), .CNT_W(16), .BLANK_CYC(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic       step;
        logic       wrap;
        logic       blank;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Model: ping-pong is a 15-position walk (0..7 ascending, 8..13 descending to 1, 14 = 0 heading back up)
    int m_sel, m_pos, m_cnt, m_age;
    bit m_step, m_wrap, m_changed;

    function automatic void chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endfunction

    function automatic int pos_to_sel(input int p);
        return (p <= 7) ? p : 14 - p;
    endfunction

    task automatic model_edge(input bit r, input bit e, input int md, input bit ld, input int lv);
        if (r) begin
            m_sel = 0; m_pos = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
            m_changed = 0; m_age = 0;
        end else if (ld) begin
            m_sel = lv; m_pos = lv; m_cnt = 0; m_step = 0; m_wrap = 0;
            m_changed = 1; m_age = 0;
        end else if (e && m_cnt == P - 1) begin
            m_cnt = 0;
            m_step = (md != 3);
            m_wrap = 0;
            case (md)
                0: begin m_wrap = (m_sel == 7); m_sel = (m_sel + 1) % 8; m_pos = m_sel; end
                1: begin m_wrap = (m_sel == 0); m_sel = (m_sel + 7) % 8; m_pos = m_sel; end
                2: begin
                    if (m_pos == 14) begin m_pos = 1; m_wrap = 1; end
                    else m_pos = m_pos + 1;
                    m_sel = pos_to_sel(m_pos);
                end
                default: m_pos = m_sel;
            endcase
            if (m_step) begin m_changed = 1; m_age = 0; end
            else if (m_age < 255) m_age++;
        end else begin
            if (e) m_cnt++;
            m_step = 0; m_wrap = 0;
            if (m_age < 255) m_age++;
        end
    endtask

    task automatic cycle(input bit rst_v, input bit en_v, input int md, input bit ld, input int lv,
                         input bit mid_rst);
        exp_t ex;
        @(negedge clk);
        rst          = rst_v;
        bus.en       = en_v;
        bus.mode     = 2'(md);
        bus.load     = ld;
        bus.load_val = 3'(lv);
        if (mid_rst) begin
            #2 rst = 1'b1;
            #1;
            chk("async_rst_sel", int'({bus.a, bus.b, bus.c}), 0);
            chk("async_rst_step", int'(bus.step), 0);
            chk("async_rst_wrap", int'(bus.wrap), 0);
`ifdef SCAN_SEL_BLANK_EN
            chk("async_rst_blank", int'(bus.blank), 0);
`endif
        end
        model_edge(rst_v | mid_rst, en_v, md, ld, lv);
        ex.sel   = 3'(m_sel);
        ex.step  = m_step;
        ex.wrap  = m_wrap;
        ex.blank = m_changed && (m_age < BL);
        q.push_back(ex);
    endtask

    // Monitor: every clock edge is a transaction; compare each field against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sel", int'({bus.a, bus.b, bus.c}), int'(e.sel));
                chk("step", int'(bus.step), int'(e.step));
                chk("wrap", int'(bus.wrap), int'(e.wrap));
`ifdef SCAN_SEL_BLANK_EN
                chk("blank", int'(bus.blank), int'(e.blank));
`endif
                if (e.step || e.wrap || bus.step || bus.wrap)
                    $display("txn t=%0t sel=%0d step=%0b wrap=%0b (exp sel=%0d step=%0b wrap=%0b)",
                             $time, {bus.a, bus.b, bus.c}, bus.step, bus.wrap, e.sel, e.step, e.wrap);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int md;
        bus.en = 1'b0; bus.mode = 2'b00; bus.load = 1'b0; bus.load_val = 3'd0;
        model_edge(1, 0, 0, 0, 0);

        // Reset, then up mode for a full scan plus margin
        repeat (2) cycle(1, 0, 0, 0, 0, 0);
        repeat (36) cycle(0, 1, 0, 0, 0, 0);

        // Down from 0 with en dropped mid-count
        repeat (2) cycle(1, 0, 1, 0, 0, 0);
        repeat (6) cycle(0, 1, 1, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 0, 0, 0);
        repeat (12) cycle(0, 1, 1, 0, 0, 0);

        // Ping-pong from reset through a full bounce
        repeat (2) cycle(1, 0, 2, 0, 0, 0);
        repeat (16 * P + 4) cycle(0, 1, 2, 0, 0, 0);

        // Load colliding with a tick
        while (m_cnt != P - 1) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 5, 0);
        repeat (P + 2) cycle(0, 1, 0, 0, 0, 0);

        // Hold, then asynchronous reset mid-cycle
        repeat (12) cycle(0, 1, 3, 0, 0, 0);
        cycle(0, 1, 3, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0);

        // Blank fall-off after en drops right after a change
        while (!m_step) cycle(0, 1, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        md = 0;
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) md = int'($urandom_range(0, 3));
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 85), md,
                  ($urandom_range(0, 24) == 0), int'($urandom_range(0, 7)), 0);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
